// File: rtl/fir_seq_ctrl.sv
// Sequencer between a CPU-side command/sample port and an AXI-Stream FIR core.
// Loads taps, launches a run, streams samples in and results out, and reports progress.
module fir_seq_ctrl #(
  parameter int TAP_NUM = 11,
  parameter int LEN_W   = 10
) (
  input  logic             axis_clk,
  input  logic             axis_rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_type,
  input  logic [31:0]      cfg_data,
  output logic             tap_we,
  output logic [3:0]       tap_addr,
  output logic [31:0]      tap_wdata,
  output logic [LEN_W-1:0] data_length,
  output logic             ap_start,
  input  logic             ap_idle,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [31:0]      x_data,
  output logic             ss_tvalid,
  input  logic             ss_tready,
  output logic [31:0]      ss_tdata,
  output logic             ss_tlast,
  input  logic             sm_tvalid,
  output logic             sm_tready,
  input  logic [31:0]      sm_tdata,
  input  logic             sm_tlast,
  output logic [15:0]      status,
  output logic [31:0]      cycle_count,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam logic [1:0]       CMD_LEN   = 2'd0;
  localparam logic [1:0]       CMD_COEF  = 2'd1;
  localparam logic [1:0]       CMD_START = 2'd2;
  localparam logic [3:0]       LAST_IDX  = 4'(TAP_NUM - 1);
  localparam logic [LEN_W-1:0] LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic             cfg_ready_r;
  logic             busy_r;
  logic             sm_tready_r;
  logic             tap_we_r;
  logic [3:0]       tap_addr_r;
  logic [31:0]      tap_wdata_r;
  logic [LEN_W-1:0] data_length_r;
  logic [15:0]      status_r;
  logic [31:0]      cycle_count_r;
  logic             err_r;
  logic [3:0]       coef_idx_r;
  logic             coef_ok_r;
  logic [LEN_W-1:0] x_cnt_r;
  logic [LEN_W-1:0] y_cnt_r;

  logic cfg_acc_s;
  logic cmd_len_s;
  logic cmd_coef_s;
  logic cmd_start_s;
  logic start_ok_s;
  logic launch_s;
  logic in_run_s;
  logic x_active_s;
  logic x_last_s;
  logic ss_hs_s;
  logic sm_hs_s;
  logic y_last_s;
  logic tlast_bad_s;
  logic run_end_s;
  logic unused_sm_s;

  assign cfg_acc_s   = cfg_valid && cfg_ready_r;
  assign cmd_len_s   = cfg_acc_s && (cfg_type == CMD_LEN);
  assign cmd_coef_s  = cfg_acc_s && (cfg_type == CMD_COEF);
  assign cmd_start_s = cfg_acc_s && (cfg_type == CMD_START);
  assign start_ok_s  = (data_length_r != LEN_ZERO) && coef_ok_r;
  assign launch_s    = (state_r == ST_WAIT_IDLE) && ap_idle;
  assign in_run_s    = (state_r == ST_RUN);
  assign x_active_s  = in_run_s && (x_cnt_r < data_length_r);
  assign x_last_s    = (x_cnt_r == (data_length_r - LEN_ONE));
  assign ss_hs_s     = x_active_s && x_valid && ss_tready;
  assign sm_hs_s     = in_run_s && sm_tvalid && sm_tready_r;
  assign y_last_s    = (y_cnt_r == (data_length_r - LEN_ONE));
  assign tlast_bad_s = sm_hs_s && (sm_tlast != y_last_s);
  assign run_end_s   = sm_hs_s && y_last_s;
  // Only the low result byte reaches the status word.
  assign unused_sm_s = ^sm_tdata[31:8];

  assign cfg_ready   = cfg_ready_r;
  assign busy        = busy_r;
  assign sm_tready   = sm_tready_r;
  assign tap_we      = tap_we_r;
  assign tap_addr    = tap_addr_r;
  assign tap_wdata   = tap_wdata_r;
  assign data_length = data_length_r;
  assign status      = status_r;
  assign cycle_count = cycle_count_r;
  assign err         = err_r;
  assign ap_start    = launch_s;

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (cmd_start_s && start_ok_s) begin
          state_nxt_s = ST_WAIT_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_WAIT_IDLE: begin
        if (ap_idle) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_WAIT_IDLE;
        end
      end
      ST_RUN: begin
        if (run_end_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Zero-latency sample pass-through while samples remain.
  always_comb begin
    ss_tvalid = 1'b0;
    x_ready   = 1'b0;
    ss_tdata  = 32'h0000_0000;
    ss_tlast  = 1'b0;
    if (x_active_s) begin
      ss_tvalid = x_valid;
      x_ready   = ss_tready;
      ss_tdata  = x_data;
      ss_tlast  = x_last_s;
    end else begin
      ss_tvalid = 1'b0;
      x_ready   = 1'b0;
      ss_tdata  = 32'h0000_0000;
      ss_tlast  = 1'b0;
    end
  end

  // State register plus the state-decoded handshake flags, taken from the next state.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_r     <= ST_IDLE;
      cfg_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      sm_tready_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cfg_ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s == ST_RUN);
      sm_tready_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Length latch and coefficient write port.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      data_length_r <= LEN_ZERO;
      tap_we_r      <= 1'b0;
      tap_addr_r    <= 4'd0;
      tap_wdata_r   <= 32'h0000_0000;
      coef_idx_r    <= 4'd0;
      coef_ok_r     <= 1'b0;
    end else begin
      tap_we_r <= cmd_coef_s;
      if (cmd_len_s) begin
        data_length_r <= cfg_data[LEN_W-1:0];
      end else begin
        data_length_r <= data_length_r;
      end
      if (cmd_coef_s) begin
        tap_addr_r  <= coef_idx_r;
        tap_wdata_r <= cfg_data;
        if (coef_idx_r == LAST_IDX) begin
          coef_idx_r <= 4'd0;
          coef_ok_r  <= 1'b1;
        end else begin
          coef_idx_r <= coef_idx_r + 4'd1;
        end
      end else begin
        tap_addr_r  <= tap_addr_r;
        tap_wdata_r <= tap_wdata_r;
      end
    end
  end

  // Progress word and sticky error.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      status_r <= 16'h0000;
      err_r    <= 1'b0;
    end else begin
      if (cmd_len_s) begin
        status_r <= 16'h00DD;
      end else if (cmd_coef_s && (coef_idx_r == LAST_IDX)) begin
        status_r <= 16'h00CC;
      end else if (launch_s) begin
        status_r <= 16'h00A5;
      end else if (run_end_s) begin
        status_r <= {sm_tdata[7:0], 8'h5A};
      end else begin
        status_r <= status_r;
      end
      if (cmd_len_s || cmd_coef_s) begin
        err_r <= 1'b0;
      end else if ((cmd_start_s && !start_ok_s) || tlast_bad_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Run counters; cycle_count saturates and freezes once the run leaves RUN.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      x_cnt_r       <= LEN_ZERO;
      y_cnt_r       <= LEN_ZERO;
      cycle_count_r <= 32'h0000_0000;
    end else if (launch_s) begin
      x_cnt_r       <= LEN_ZERO;
      y_cnt_r       <= LEN_ZERO;
      cycle_count_r <= 32'h0000_0000;
    end else begin
      if (ss_hs_s) begin
        x_cnt_r <= x_cnt_r + LEN_ONE;
      end else begin
        x_cnt_r <= x_cnt_r;
      end
      if (sm_hs_s) begin
        y_cnt_r <= y_cnt_r + LEN_ONE;
      end else begin
        y_cnt_r <= y_cnt_r;
      end
      if (in_run_s && (cycle_count_r != 32'hFFFF_FFFF)) begin
        cycle_count_r <= cycle_count_r + 32'd1;
      end else begin
        cycle_count_r <= cycle_count_r;
      end
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: a phase-level model checked every falling edge,
// plus hand-computed expectations at the key points of each scenario.
module tb_fir_seq_ctrl;

  localparam int NT = 11;
  localparam logic [1:0] T_LEN   = 2'd0;
  localparam logic [1:0] T_COEF  = 2'd1;
  localparam logic [1:0] T_START = 2'd2;

  logic        axis_clk   = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        cfg_valid  = 1'b0;
  logic [1:0]  cfg_type   = 2'd0;
  logic [31:0] cfg_data   = 32'h0;
  logic        ap_idle    = 1'b0;
  logic        x_valid    = 1'b0;
  logic [31:0] x_data     = 32'h0;
  logic        ss_tready  = 1'b0;
  logic        sm_tvalid  = 1'b0;
  logic [31:0] sm_tdata   = 32'h0;
  logic        sm_tlast   = 1'b0;

  logic        cfg_ready, tap_we, ap_start, x_ready, ss_tvalid, ss_tlast, sm_tready, busy, err;
  logic [3:0]  tap_addr;
  logic [31:0] tap_wdata, ss_tdata, cycle_count;
  logic [9:0]  data_length;
  logic [15:0] status;

  always #5 axis_clk = ~axis_clk;

  fir_seq_ctrl #(.TAP_NUM(NT), .LEN_W(10)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_type(cfg_type), .cfg_data(cfg_data),
    .tap_we(tap_we), .tap_addr(tap_addr), .tap_wdata(tap_wdata),
    .data_length(data_length), .ap_start(ap_start), .ap_idle(ap_idle),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .status(status), .cycle_count(cycle_count), .busy(busy), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for FIR idle, 2 running, 3 done.
  int          m_phase  = 0;
  bit          m_up     = 1'b0;
  int          m_len    = 0;
  int          m_ncoef  = 0;
  bit          m_ok     = 1'b0;
  bit          m_err    = 1'b0;
  logic [15:0] m_status = 16'h0;
  logic [31:0] m_cyc    = 32'h0;
  int          m_xn     = 0;
  int          m_yn     = 0;
  logic [35:0] tapq[$];

  always @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      m_phase <= 0; m_up <= 1'b0; m_len <= 0; m_ncoef <= 0; m_ok <= 1'b0;
      m_err <= 1'b0; m_status <= 16'h0; m_cyc <= 32'h0; m_xn <= 0; m_yn <= 0;
      tapq.delete();
    end else begin
      m_up <= 1'b1;
      if (m_up && (m_phase == 0 || m_phase == 3) && cfg_valid) begin
        case (cfg_type)
          T_LEN: begin
            m_len <= int'(cfg_data[9:0]); m_status <= 16'h00DD; m_err <= 1'b0;
          end
          T_COEF: begin
            tapq.push_back({4'(m_ncoef % NT), cfg_data});
            m_ncoef <= m_ncoef + 1;
            m_err   <= 1'b0;
            if ((m_ncoef + 1) % NT == 0) begin
              m_ok <= 1'b1; m_status <= 16'h00CC;
            end
          end
          T_START: begin
            if (m_len != 0 && m_ok) m_phase <= 1;
            else m_err <= 1'b1;
          end
          default: ;
        endcase
      end
      if (m_phase == 1 && ap_idle) begin
        m_phase <= 2; m_status <= 16'h00A5; m_xn <= 0; m_yn <= 0; m_cyc <= 32'h0;
      end
      if (m_phase == 2) begin
        if (m_cyc != 32'hFFFF_FFFF) m_cyc <= m_cyc + 32'd1;
        if (x_valid && ss_tready && m_xn < m_len) m_xn <= m_xn + 1;
        if (sm_tvalid) begin
          m_yn <= m_yn + 1;
          if (sm_tlast != (m_yn == m_len - 1)) m_err <= 1'b1;
          if (m_yn == m_len - 1) begin
            m_phase <= 3; m_status <= {sm_tdata[7:0], 8'h5A};
          end
        end
      end
    end
  end

  logic e_active;
  assign e_active = (m_phase == 2) && (m_xn < m_len);

  always @(negedge axis_clk) begin
    check("cfg_ready", {31'b0, cfg_ready}, {31'b0, m_up && (m_phase == 0 || m_phase == 3)});
    check("busy", {31'b0, busy}, {31'b0, m_phase == 2});
    check("sm_tready", {31'b0, sm_tready}, {31'b0, m_phase == 2});
    check("ap_start", {31'b0, ap_start}, {31'b0, m_phase == 1 && ap_idle});
    check("ss_tvalid", {31'b0, ss_tvalid}, {31'b0, e_active && x_valid});
    check("x_ready", {31'b0, x_ready}, {31'b0, e_active && ss_tready});
    check("ss_tdata", ss_tdata, e_active ? x_data : 32'h0);
    check("ss_tlast", {31'b0, ss_tlast}, {31'b0, e_active && (m_xn == m_len - 1)});
    check("data_length", {22'b0, data_length}, 32'(m_len));
    check("status", {16'b0, status}, {16'b0, m_status});
    check("cycle_count", cycle_count, m_cyc);
    check("err", {31'b0, err}, {31'b0, m_err});
    if (tapq.size() > 0) begin
      check("tap_we", {31'b0, tap_we}, 32'd1);
      check("tap_addr", {28'b0, tap_addr}, {28'b0, tapq[0][35:32]});
      check("tap_wdata", tap_wdata, tapq[0][31:0]);
      void'(tapq.pop_front());
    end else begin
      check("tap_we", {31'b0, tap_we}, 32'd0);
    end
  end

  task automatic cyc();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] t, input logic [31:0] d);
    int b = 0;
    cfg_type  = t;
    cfg_data  = d;
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && b < 50) begin
      cyc();
      b++;
    end
    if (b >= 50) check("cmd_timeout", 32'(b), 32'd0);
    cyc();
    cfg_valid = 1'b0;
  endtask

  // One run of n samples; abort_at > 0 leaves the run in progress after that many samples.
  task automatic do_run(input int n, input logic [7:0] last_y, input int bad_idx, input int abort_at);
    int xs = 0;
    int ys = 0;
    int rc = 0;
    int tl = 0;
    ap_idle = 1'b0;
    cmd(T_START, 32'h0);
    repeat (5) begin
      cyc();
      check("ap_start_held", {31'b0, ap_start}, 32'd0);
    end
    ap_idle = 1'b1;
    #1;
    check("ap_start_pulse", {31'b0, ap_start}, 32'd1);
    cyc();
    ap_idle = 1'b0;
    check("status_a5", {16'b0, status}, 32'h0000_00A5);
    while (ys < n && rc < 3000) begin
      if (abort_at > 0 && xs >= abort_at) break;
      x_valid   = (xs < n);
      x_data    = 32'h1000 + 32'(xs);
      ss_tready = 1'($urandom_range(0, 1));
      sm_tvalid = (ys < xs) && ($urandom_range(0, 3) != 0);
      sm_tdata  = (ys == n - 1) ? {24'h0, last_y} : 32'(ys * 7);
      sm_tlast  = (ys == n - 1) || (ys == bad_idx);
      #1;
      if (ss_tlast === 1'b1) check("ss_tlast_pos", 32'(xs), 32'(n - 1));
      if (x_valid && ss_tready && ss_tlast) tl++;
      @(posedge axis_clk);
      #1;
      rc++;
      if (x_valid && ss_tready) xs++;
      if (sm_tvalid) ys++;
    end
    if (abort_at == 0) begin
      x_valid = 1'b0; ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tlast = 1'b0; x_data = 32'h0;
      check("run_complete", 32'(ys), 32'(n));
      check("status_end", {16'b0, status}, {16'b0, last_y, 8'h5A});
      check("cycle_count_run", cycle_count, 32'(rc));
      check("ss_tlast_count", 32'(tl), 32'd1);
      check("busy_done", {31'b0, busy}, 32'd0);
      check("err_run", {31'b0, err}, (bad_idx >= 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int coefs[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    repeat (3) cyc();
    check("rst_status", {16'b0, status}, 32'h0);
    check("rst_ready", {31'b0, cfg_ready}, 32'd0);
    check("rst_len", {22'b0, data_length}, 32'd0);
    axis_rst_n = 1'b1;
    cyc();
    check("ready_after_rst", {31'b0, cfg_ready}, 32'd1);

    cmd(T_START, 32'h0);
    check("err_start_empty", {31'b0, err}, 32'd1);
    cmd(T_LEN, 32'd64);
    check("err_cleared_len", {31'b0, err}, 32'd0);
    check("status_dd", {16'b0, status}, 32'h0000_00DD);
    check("len_64", {22'b0, data_length}, 32'd64);
    cmd(T_START, 32'h0);
    check("err_start_nocoef", {31'b0, err}, 32'd1);
    check("idle_after_bad", {31'b0, busy}, 32'd0);

    for (int i = 0; i < NT; i++) begin
      cmd(T_COEF, 32'(coefs[i]));
      check("coef_we", {31'b0, tap_we}, 32'd1);
      check("coef_addr", {28'b0, tap_addr}, 32'(i));
      check("coef_data", tap_wdata, 32'(coefs[i]));
      check("coef_status", {16'b0, status}, (i == NT - 1) ? 32'h0000_00CC : 32'h0000_00DD);
    end

    cmd(T_LEN, 32'd0);
    cmd(T_START, 32'h0);
    check("err_start_len0", {31'b0, err}, 32'd1);
    check("ready_len0", {31'b0, cfg_ready}, 32'd1);
    cmd(T_LEN, 32'd64);
    check("err_clear2", {31'b0, err}, 32'd0);

    do_run(64, 8'h37, -1, 0);
    do_run(64, 8'h12, -1, 0);
    do_run(64, 8'h9C, -1, 0);
    do_run(64, 8'h5E, 10, 0);

    cmd(T_LEN, 32'd64);
    do_run(64, 8'h00, -1, 10);
    x_valid   = 1'b1;
    ss_tready = 1'b1;
    sm_tvalid = 1'b0;
    #1;
    axis_rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_status", {16'b0, status}, 32'h0);
    check("mid_rst_cycles", cycle_count, 32'h0);
    check("mid_rst_len", {22'b0, data_length}, 32'h0);
    check("mid_rst_ss", {29'b0, ss_tvalid, x_ready, sm_tready}, 32'h0);
    check("mid_rst_ready", {31'b0, cfg_ready}, 32'd0);
    repeat (2) cyc();
    axis_rst_n = 1'b1;
    x_valid    = 1'b0;
    ss_tready  = 1'b0;
    cyc();
    cmd(T_LEN, 32'd64);
    cmd(T_START, 32'h0);
    check("err_after_rst", {31'b0, err}, 32'd1);
    cyc();
    check("idle_after_rst", {31'b0, busy}, 32'd0);
    check("ready_after_rst2", {31'b0, cfg_ready}, 32'd1);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameter TAP_NUM, default 11, number of FIR coefficients.
REQ-002 SHALL have parameter LEN_W, default 10, width of the data-length field.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: axis_clk and axis_rst_n.
REQ-004 axis_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 axis_rst_n  in  1  asynchronous active-low reset.
REQ-006 cfg_valid / cfg_ready  in / out  1 / 1  command handshake.
REQ-007 cfg_type  in  2  command: 0=LEN, 1=COEF, 2=START, 3=reserved.
REQ-008 cfg_data  in  32  command payload.
REQ-009 tap_we / tap_addr / tap_wdata  out  1 / 4 / 32  coefficient write port to the FIR tap RAM.
REQ-010 data_length  out  LEN_W  programmed sample count.
REQ-011 ap_start / ap_idle  out / in  1 / 1  FIR start pulse and idle flag.
REQ-012 x_valid / x_ready / x_data  in / out / in  1 / 1 / 32  input samples from the CPU.
REQ-013 ss_tvalid / ss_tready / ss_tdata / ss_tlast  out / in / out / out  1 / 1 / 32 / 1  AXI-Stream to FIR.
REQ-014 sm_tvalid / sm_tready / sm_tdata / sm_tlast  in / out / in / in  1 / 1 / 32 / 1  AXI-Stream from FIR.
REQ-015 status  out  16  progress word for the GPIO check bits.
REQ-016 cycle_count  out  32  run latency in cycles.
REQ-017 busy, err  out  1 each  run in progress; sticky protocol error.

Function
REQ-018 FSM states: IDLE, WAIT_IDLE, RUN, DONE.
REQ-019 cfg_ready SHALL be 1 in IDLE and DONE and 0 otherwise; a command is accepted on cfg_valid&&cfg_ready.
REQ-020 An accepted LEN command SHALL latch data_length=cfg_data[LEN_W-1:0] and set status=16'h00DD.
REQ-021 An accepted COEF command SHALL produce, on the next cycle, a one-cycle tap_we with tap_addr=coef_idx and tap_wdata=cfg_data.
REQ-022 After each COEF write, coef_idx SHALL increment, wrapping from TAP_NUM-1 to 0; on the TAP_NUM-th write coef_ok SHALL be set and status=16'h00CC.
REQ-023 coef_ok SHALL persist across runs and clear only on reset.
REQ-024 An accepted START with data_length!=0 and coef_ok=1 SHALL enter WAIT_IDLE; any other START SHALL set err and leave the state unchanged.
REQ-025 err SHALL clear on the next accepted LEN or COEF command.
REQ-026 In WAIT_IDLE, the first cycle with ap_idle=1 SHALL assert ap_start for exactly one cycle, set status=16'h00A5, clear x_cnt, y_cnt and cycle_count, and enter RUN.
REQ-027 In RUN, busy=1 and cycle_count SHALL increment by 1 each cycle, saturating at 32'hFFFFFFFF.
REQ-028 In RUN with x_cnt<data_length: ss_tvalid=x_valid, x_ready=ss_tready, ss_tdata=x_data, all combinational (zero latency).
REQ-029 In RUN with x_cnt<data_length: ss_tlast=1 exactly when x_cnt==data_length-1.
REQ-030 Once x_cnt==data_length, ss_tvalid and x_ready SHALL be 0.
REQ-031 sm_tready SHALL be 1 in RUN only; each sm handshake SHALL increment y_cnt and latch last_y=sm_tdata.
REQ-032 sm_tlast=1 with y_cnt!=data_length-1, or sm_tlast=0 with y_cnt==data_length-1, SHALL set err; the run still ends by count.
REQ-033 The sm handshake with y_cnt==data_length-1 SHALL move the FSM to DONE on the next edge with status={last_y[7:0],8'h5A}, busy=0, cycle_count frozen.
REQ-034 A simultaneous ss and sm handshake in the same cycle SHALL update both counters.
REQ-035 In DONE, START SHALL rerun with the retained coefficients; LEN and COEF SHALL be accepted as in IDLE.
REQ-036 Commands presented in WAIT_IDLE or RUN SHALL be stalled (cfg_ready=0), never dropped.

Reset
REQ-037 Asserting axis_rst_n=0 at any time, including mid-RUN, SHALL immediately force IDLE and set: all outputs 0, status=16'h0000, cycle_count=0, data_length=0, coef_idx=0, coef_ok=0, err=0.

Verification
REQ-038 LEN 64, then 11 COEF {0,-10,-9,23,56,63,56,23,-9,-10,0} -> status 00DD, then 00CC; tap_addr 0..10 in order with matching tap_wdata.
REQ-039 START with ap_idle held 0 for 5 cycles -> ap_start is a single pulse on the first ap_idle=1 cycle; status=00A5.
REQ-040 64 samples with ss_tready toggling randomly and FIR returning 64 Y (last Y=0x37) -> ss_tlast only on sample 63, status=375A, cycle_count equals cycles in RUN.
REQ-041 START before the coefficient load completes, or with LEN 0 -> err=1, FSM stays in IDLE; a subsequent LEN clears err.
REQ-042 Three back-to-back STARTs from DONE -> three runs, each ending with the xx5A status, with no coefficient reload.
REQ-043 Reset asserted mid-RUN after 10 samples -> all outputs at their reset values; a following START without COEF reload sets err.
